// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
// The optional REGFILE_ARB_STATS_EN macro does not alter anything in this package.
package regfile_arb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int unsigned ZERO_REG = 0;

endpackage : regfile_arb_pkg

// File: rtl/regfile_write_arbiter_rr.sv
// Two-way round-robin grant. The pointer names the requester that wins the next tie,
// and it moves past whoever was just granted.
module rr_arbiter2
  import regfile_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection and pointer next-state
  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    ptr_d   = ptr_q;
    if (en_i) begin
      if (req_a_i && (!req_b_i || (ptr_q == REQ_A))) begin
        gnt_a_o = 1'b1;
      end else if (req_b_i) begin
        gnt_b_o = 1'b1;
      end else begin
        gnt_a_o = 1'b0;
      end
    end else begin
      gnt_a_o = 1'b0;
    end
    if (gnt_a_o) begin
      ptr_d = REQ_B;
    end else if (gnt_b_o) begin
      ptr_d = REQ_A;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= REQ_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arbiter2

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between requesters A and B after clearing regs 1..NUM_REGS-1.
// Define REGFILE_ARB_STATS_EN to add the saturating StallCountA/StallCountB outputs.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ValidA,
  output logic                  ReadyA,
  input  logic [ADDR_WIDTH-1:0] AddrA,
  input  logic [DATA_WIDTH-1:0] DataA,
  input  logic                  ValidB,
  output logic                  ReadyB,
  input  logic [ADDR_WIDTH-1:0] AddrB,
  input  logic [DATA_WIDTH-1:0] DataB,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  RegWrite,
`ifdef REGFILE_ARB_STATS_EN
  output logic [15:0]           StallCountA,
  output logic [15:0]           StallCountB,
`endif
  output logic                  InitDone
);

  localparam logic [ADDR_WIDTH-1:0] LAST_REG  = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  arb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  reg_write_q, reg_write_d;
  logic                  init_done_q, init_done_d;
  logic                  gnt_a_s, gnt_b_s;

  rr_arbiter2 u_rr (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .en_i    (state_q == ST_RUN),
    .req_a_i (ValidA),
    .req_b_i (ValidB),
    .gnt_a_o (gnt_a_s),
    .gnt_b_o (gnt_b_s)
  );

  assign ReadyA        = gnt_a_s;
  assign ReadyB        = gnt_b_s;
  assign WriteRegister = wr_reg_q;
  assign WriteData     = wr_data_q;
  assign RegWrite      = reg_write_q;
  assign InitDone      = init_done_q;

  // FSM next-state, clear sequencing and write-port staging
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    reg_write_d = 1'b0;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        wr_reg_d    = cnt_q;
        wr_data_d   = '0;
        reg_write_d = 1'b1;
        cnt_d       = cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_REG) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          state_d     = ST_INIT;
        end
      end
      ST_RUN: begin
        init_done_d = 1'b1;
        // Register 0 requests are accepted but never reach the write enable
        if (gnt_a_s) begin
          wr_reg_d    = AddrA;
          wr_data_d   = DataA;
          reg_write_d = (AddrA != ZERO_ADDR);
        end else if (gnt_b_s) begin
          wr_reg_d    = AddrB;
          wr_data_d   = DataB;
          reg_write_d = (AddrB != ZERO_ADDR);
        end else begin
          reg_write_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      reg_write_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      reg_write_q <= reg_write_d;
      init_done_q <= init_done_d;
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] stall_a_q, stall_a_d;
  logic [15:0] stall_b_q, stall_b_d;
  logic        stall_a_s, stall_b_s;

  assign stall_a_s   = (state_q == ST_RUN) && ValidA && !gnt_a_s;
  assign stall_b_s   = (state_q == ST_RUN) && ValidB && !gnt_b_s;
  assign StallCountA = stall_a_q;
  assign StallCountB = stall_b_q;

  // Saturating stall counters
  always_comb begin
    stall_a_d = stall_a_q;
    stall_b_d = stall_b_q;
    if (stall_a_s && (stall_a_q != 16'hFFFF)) begin
      stall_a_d = stall_a_q + 16'd1;
    end else begin
      stall_a_d = stall_a_q;
    end
    if (stall_b_s && (stall_b_q != 16'hFFFF)) begin
      stall_b_d = stall_b_q + 16'd1;
    end else begin
      stall_b_d = stall_b_q;
    end
  end

  // Stall counter registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_a_q <= 16'd0;
      stall_b_q <= 16'd0;
    end else begin
      stall_a_q <= stall_a_d;
      stall_b_q <= stall_b_d;
    end
  end
`endif

endmodule : regfile_write_arbiter
